// File: rtl/sobel_stream.sv
// sobel_stream: streaming 3x3 Sobel edge detector over a raster-order frame.
// Two line buffers plus a 3x3 column-shifting window feed a combinational
// Gx/Gy stage; each result is registered into a valid/ready output slot.
// Out-of-image neighbours are masked to zero using the result coordinates,
// so the line buffers never need clearing between frames.
//
// Handshakes: an input pixel transfers when DataValid & DataReady are high on
// a rising edge; a result transfers when OutValid & OutReady are high. While
// OutValid=1 and OutReady=0 every result output holds its value.
module sobel_stream #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int MODE  = 0
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PIX_W-1:0] Threshold,
  input  logic [PIX_W-1:0] DataIn,
  input  logic             DataValid,
  output logic             DataReady,
  input  logic             OutReady,
  output logic             OutValid,
  output logic [PIX_W-1:0] Gradient,
  output logic             Dop,
  output logic [15:0]      OutRow,
  output logic [15:0]      OutCol,
  output logic             Finish,
  output logic [1:0]       State
);

  localparam int CAW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int GW  = PIX_W + 4;
  localparam logic [15:0]   COL_LAST  = 16'(IMG_W - 1);
  localparam logic [15:0]   ROW_LAST  = 16'(IMG_H - 1);
  localparam logic [15:0]   FLUSH_ROW = 16'(IMG_H + 1);
  localparam logic [GW-1:0] SAT_MAX   = {4'b0000, {PIX_W{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PIX_W-1:0] thr_q, thr_d;
  logic [15:0]      in_row_q, in_row_d, in_col_q, in_col_d;
  logic [15:0]      res_row_q, res_row_d, res_col_q, res_col_d;
  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] grad_q, grad_d;
  logic             dop_q, dop_d;
  logic [15:0]      out_row_q, out_row_d, out_col_q, out_col_d;
  // window indexed [column][row]: column 0 = left, row 0 = top
  logic [PIX_W-1:0] win_q [3][3];
  logic [PIX_W-1:0] win_d [3][3];

  logic [PIX_W-1:0] lb0_mem [IMG_W];  // previous row
  logic [PIX_W-1:0] lb1_mem [IMG_W];  // row before that

  logic             slot_free, in_xfer, flush_live, flush_step, step;
  logic             primed, produce;
  logic [CAW-1:0]   col_idx;
  logic [PIX_W-1:0] pix_in, lb0_rd, lb1_rd;
  logic             m_l, m_r, m_t, m_b;
  logic [GW-1:0]    t_tl, t_tm, t_tr, t_ml, t_mr, t_bl, t_bm, t_br;
  logic [GW-1:0]    gx, gy, ax, ay, mag;
  logic [PIX_W-1:0] grad_new;
  logic             dop_new;

  function automatic logic [GW-1:0] tap(input logic [PIX_W-1:0] v, input logic kill);
    tap = kill ? '0 : {4'b0000, v};
  endfunction

  assign slot_free  = ~out_valid_q | OutReady;
  assign DataReady  = (state_q == S_RUN) & slot_free;
  assign in_xfer    = DataValid & DataReady;
  // Flush stops once the zero position at (IMG_H+1, 0) has been injected.
  assign flush_live = !((in_row_q == FLUSH_ROW) && (in_col_q != 16'd0));
  assign flush_step = (state_q == S_FLUSH) & slot_free & flush_live;
  assign step       = in_xfer | flush_step;
  assign pix_in     = (state_q == S_RUN) ? DataIn : '0;
  assign col_idx    = in_col_q[CAW-1:0];
  assign lb0_rd     = lb0_mem[col_idx];
  assign lb1_rd     = lb1_mem[col_idx];
  // A result exists once position IMG_W+1 of the raster has been stepped.
  assign primed     = (in_row_q >= 16'd2) || ((in_row_q == 16'd1) && (in_col_q != 16'd0));
  assign produce    = step & primed;

  // Window shift: new column is {row-2, row-1, incoming pixel}.
  always_comb begin
    win_d = win_q;
    if (step) begin
      win_d[0]    = win_q[1];
      win_d[1]    = win_q[2];
      win_d[2][0] = lb1_rd;
      win_d[2][1] = lb0_rd;
      win_d[2][2] = pix_in;
    end
  end

  // Sobel on the post-shift window, masked around the result centre.
  always_comb begin
    m_l  = (res_col_q == 16'd0);
    m_r  = (res_col_q == COL_LAST);
    m_t  = (res_row_q == 16'd0);
    m_b  = (res_row_q == ROW_LAST);
    t_tl = tap(win_d[0][0], m_l | m_t);
    t_tm = tap(win_d[1][0], m_t);
    t_tr = tap(win_d[2][0], m_r | m_t);
    t_ml = tap(win_d[0][1], m_l);
    t_mr = tap(win_d[2][1], m_r);
    t_bl = tap(win_d[0][2], m_l | m_b);
    t_bm = tap(win_d[1][2], m_b);
    t_br = tap(win_d[2][2], m_r | m_b);
    gx   = (t_tr + (t_mr << 1) + t_br) - (t_tl + (t_ml << 1) + t_bl);
    gy   = (t_bl + (t_bm << 1) + t_br) - (t_tl + (t_tm << 1) + t_tr);
    ax   = gx[GW-1] ? (~gx + 1'b1) : gx;
    ay   = gy[GW-1] ? (~gy + 1'b1) : gy;
    if (MODE == 0) mag = ax + ay;
    else           mag = (ax > ay) ? ax : ay;
    grad_new = (mag > SAT_MAX) ? {PIX_W{1'b1}} : mag[PIX_W-1:0];
    dop_new  = (grad_new > thr_q);
  end

  // Next-state, counters and output slot.
  always_comb begin
    state_d     = state_q;
    thr_d       = thr_q;
    in_row_d    = in_row_q;
    in_col_d    = in_col_q;
    res_row_d   = res_row_q;
    res_col_d   = res_col_q;
    out_valid_d = out_valid_q;
    grad_d      = grad_q;
    dop_d       = dop_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    case (state_q)
      S_IDLE: if (Start) begin
        state_d   = S_RUN;
        thr_d     = Threshold;
        in_row_d  = '0;
        in_col_d  = '0;
        res_row_d = '0;
        res_col_d = '0;
      end
      S_RUN: if (in_xfer && (in_row_q == ROW_LAST) && (in_col_q == COL_LAST)) state_d = S_FLUSH;
      S_FLUSH: if (!flush_live && out_valid_q && OutReady &&
                   (out_row_q == ROW_LAST) && (out_col_q == COL_LAST)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (step) begin
      if (in_col_q == COL_LAST) begin
        in_col_d = '0;
        in_row_d = in_row_q + 16'd1;
      end else begin
        in_col_d = in_col_q + 16'd1;
      end
    end
    if (out_valid_q && OutReady) out_valid_d = 1'b0;
    if (produce) begin
      out_valid_d = 1'b1;
      grad_d      = grad_new;
      dop_d       = dop_new;
      out_row_d   = res_row_q;
      out_col_d   = res_col_q;
      if (res_col_q == COL_LAST) begin
        res_col_d = '0;
        res_row_d = res_row_q + 16'd1;
      end else begin
        res_col_d = res_col_q + 16'd1;
      end
    end
  end

  // State, counter, window and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      thr_q       <= '0;
      in_row_q    <= '0;
      in_col_q    <= '0;
      res_row_q   <= '0;
      res_col_q   <= '0;
      out_valid_q <= 1'b0;
      grad_q      <= '0;
      dop_q       <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      win_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      thr_q       <= thr_d;
      in_row_q    <= in_row_d;
      in_col_q    <= in_col_d;
      res_row_q   <= res_row_d;
      res_col_q   <= res_col_d;
      out_valid_q <= out_valid_d;
      grad_q      <= grad_d;
      dop_q       <= dop_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      win_q       <= win_d;
    end
  end

  // Line buffers: age one row per step; contents are never cleared.
  always_ff @(posedge CLK) begin
    if (step) begin
      lb1_mem[col_idx] <= lb0_rd;
      lb0_mem[col_idx] <= pix_in;
    end
  end

  assign OutValid = out_valid_q;
  assign Gradient = grad_q;
  assign Dop      = dop_q;
  assign OutRow   = out_row_q;
  assign OutCol   = out_col_q;
  assign Finish   = (state_q == S_DONE);
  assign State    = state_q;

endmodule

// File: tb/tb_sobel_stream.sv
// tb_sobel_stream: 4x4 frames driven into a MODE=0 and a MODE=1 instance
// sharing the same inputs; results are checked against an arithmetic Sobel
// model of the image held in the bench.
module tb_sobel_stream;
  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  // clock / reset
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       Reset, Start, DataValid, OutReady;
  logic [7:0] Threshold, DataIn;
  logic       dr0, ov0, dop0, fin0, dr1, ov1, dop1, fin1;
  logic [7:0] g0, g1;
  logic [15:0] row0, col0, row1, col1;
  logic [1:0] st0, st1;

  sobel_stream #(.PIX_W(8), .IMG_W(W), .IMG_H(H), .MODE(0)) dut0 (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Threshold(Threshold),
    .DataIn(DataIn), .DataValid(DataValid), .DataReady(dr0),
    .OutReady(OutReady), .OutValid(ov0), .Gradient(g0), .Dop(dop0),
    .OutRow(row0), .OutCol(col0), .Finish(fin0), .State(st0));

  sobel_stream #(.PIX_W(8), .IMG_W(W), .IMG_H(H), .MODE(1)) dut1 (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Threshold(Threshold),
    .DataIn(DataIn), .DataValid(DataValid), .DataReady(dr1),
    .OutReady(OutReady), .OutValid(ov1), .Gradient(g1), .Dop(dop1),
    .OutRow(row1), .OutCol(col1), .Finish(fin1), .State(st1));

  int n_checks = 0;
  int n_fail   = 0;
  bit stall_out = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model
  int img [H][W];
  logic [40:0] exp_q0 [$];
  logic [40:0] exp_q1 [$];

  function automatic int pxv(int r, int c);
    if (r < 0 || r >= H || c < 0 || c >= W) return 0;
    return img[r][c];
  endfunction

  function automatic logic [40:0] model(int mode, int r, int c, int thr);
    int gx, gy, ax, ay, mag, g;
    gx = (pxv(r-1, c+1) + 2*pxv(r, c+1) + pxv(r+1, c+1))
       - (pxv(r-1, c-1) + 2*pxv(r, c-1) + pxv(r+1, c-1));
    gy = (pxv(r+1, c-1) + 2*pxv(r+1, c) + pxv(r+1, c+1))
       - (pxv(r-1, c-1) + 2*pxv(r-1, c) + pxv(r-1, c+1));
    ax  = (gx < 0) ? -gx : gx;
    ay  = (gy < 0) ? -gy : gy;
    mag = (mode == 0) ? ax + ay : ((ax > ay) ? ax : ay);
    g   = (mag > 255) ? 255 : mag;
    return {16'(r), 16'(c), 8'(g), 1'(g > thr)};
  endfunction

  task automatic push_expected(input int thr);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        exp_q0.push_back(model(0, r, c, thr));
        exp_q1.push_back(model(1, r, c, thr));
      end
  endtask

  task automatic fill_const(input int v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = v;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(0, 255));
  endtask

  // downstream ready generator
  initial begin
    OutReady = 1'b1;
    forever begin
      @(posedge CLK); #1;
      OutReady = stall_out ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // scoreboard / monitor
  logic [40:0] obs0, obs1, held0, held1;
  bit          hold_v = 0;
  int          res_cnt0 = 0, fin_cnt0 = 0, fin_cnt1 = 0;
  logic [8:0]  got0 [H][W];
  logic [8:0]  got1 [H][W];
  assign obs0 = {row0, col0, g0, dop0};
  assign obs1 = {row1, col1, g1, dop1};

  always @(negedge CLK) begin
    if (Reset) begin
      hold_v = 0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 64'(ov0 & ov1), 64'(1));
        chk("hold_data0", 64'(obs0), 64'(held0));
        chk("hold_data1", 64'(obs1), 64'(held1));
      end
      if (ov0 && OutReady) begin
        chk("result_avail0", 64'(exp_q0.size() != 0), 64'(1));
        if (exp_q0.size() != 0) chk("result0", 64'(obs0), 64'(exp_q0.pop_front()));
        got0[row0[1:0]][col0[1:0]] = {g0, dop0};
        res_cnt0++;
      end
      if (ov1 && OutReady) begin
        chk("result_avail1", 64'(exp_q1.size() != 0), 64'(1));
        if (exp_q1.size() != 0) chk("result1", 64'(obs1), 64'(exp_q1.pop_front()));
        got1[row1[1:0]][col1[1:0]] = {g1, dop1};
      end
      if (fin0) begin
        fin_cnt0++;
        chk("finish_in_done", 64'(st0), 64'(3));
      end
      if (fin1) fin_cnt1++;
      hold_v = ov0 && !OutReady;
      held0  = obs0;
      held1  = obs1;
    end
  end

  // driver tasks
  task automatic send_pixel(input logic [7:0] v, input bit stall);
    bit done;
    int guard;
    done = 0;
    guard = 0;
    DataIn = v;
    while (!done && guard < 500) begin
      DataValid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge CLK);
      done = DataValid && dr0;
      @(posedge CLK); #1;
      guard++;
    end
    DataValid = 1'b0;
    chk("pixel_accepted", 64'(done), 64'(1));
  endtask

  task automatic send_frame(input int n, input bit stall, input bit pulse_mid);
    for (int i = 0; i < n; i++) begin
      send_pixel(8'(img[i / W][i % W]), stall);
      if (pulse_mid && i == 5) begin
        Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        chk("start_ignored_in_run", 64'(st0), 64'(1));
      end
    end
  endtask

  task automatic start_frame(input int thr);
    Threshold = 8'(thr);
    Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    Threshold = 8'($urandom_range(0, 255));
    chk("run_after_start", 64'(st0), 64'(1));
  endtask

  // returns at the rising edge that leaves DONE
  task automatic wait_finish(input int target);
    int guard;
    guard = 0;
    while (fin_cnt0 < target && guard < 4000) begin
      @(posedge CLK);
      guard++;
    end
    chk("finish_seen", 64'(fin_cnt0 >= target), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int thr;
    Reset = 1'b1; Start = 1'b0; DataValid = 1'b0; DataIn = '0; Threshold = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_state", 64'(st0), 64'(0));
    chk("rst_ready", 64'(dr0), 64'(0));
    chk("rst_valid", 64'(ov0), 64'(0));
    chk("rst_grad", 64'(g0), 64'(0));
    chk("rst_dop", 64'(dop0), 64'(0));
    chk("rst_row", 64'(row0), 64'(0));
    chk("rst_col", 64'(col0), 64'(0));
    chk("rst_finish", 64'(fin0), 64'(0));
    @(posedge CLK); #1;
    Reset = 1'b0;

    // flat image of 10s, no stalls
    fill_const(10);
    push_expected(10);
    start_frame(10);
    send_frame(N, 0, 0);
    wait_finish(1);
    #1;
    chk("idle_after_frame", 64'(st0), 64'(0));
    @(negedge CLK);
    chk("finish_one_cycle", 64'(fin0), 64'(0));
    chk("result_count", 64'(res_cnt0), 64'(16));
    chk("m0_r0c0", 64'(got0[0][0]), 64'({8'd60, 1'b1}));
    chk("m0_r0c1", 64'(got0[0][1]), 64'({8'd40, 1'b1}));
    chk("m0_r1c1", 64'(got0[1][1]), 64'({8'd0, 1'b0}));
    chk("m1_r0c0", 64'(got1[0][0]), 64'({8'd30, 1'b1}));
    chk("m1_r0c1", 64'(got1[0][1]), 64'({8'd40, 1'b1}));
    chk("m1_r1c1", 64'(got1[1][1]), 64'({8'd0, 1'b0}));

    // saturation with both sides stalling
    stall_out = 1;
    fill_const(255);
    push_expected(10);
    @(posedge CLK); #1;
    start_frame(10);
    send_frame(N, 1, 0);
    wait_finish(2);
    #1;
    chk("sat_r0c0", 64'(got0[0][0]), 64'({8'd255, 1'b1}));

    // random frame with a Start pulse mid-run, then Start held through DONE
    fill_rand();
    thr = int'($urandom_range(0, 255));
    push_expected(thr);
    start_frame(thr);
    send_frame(N, 1, 1);
    fill_rand();
    thr = int'($urandom_range(0, 255));
    push_expected(thr);
    Threshold = 8'(thr);
    Start = 1'b1;
    wait_finish(3);
    #1;
    chk("start_ignored_in_done", 64'(st0), 64'(0));
    @(posedge CLK); #1;
    Start = 1'b0;
    Threshold = 8'($urandom_range(0, 255));
    chk("chained_start", 64'(st0), 64'(1));
    send_frame(N, 1, 0);
    wait_finish(4);
    #1;
    repeat (10) @(posedge CLK);
    #1;
    chk("quiet_state", 64'(st0), 64'(0));
    chk("quiet_valid", 64'(ov0), 64'(0));
    chk("one_frame_per_start", 64'(fin_cnt0), 64'(4));

    // reset in the middle of a frame
    fill_rand();
    push_expected(int'($urandom_range(0, 255)));
    start_frame(50);
    send_frame(7, 1, 0);
    Reset = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    @(posedge CLK);
    @(negedge CLK);
    chk("mid_rst_state", 64'(st0), 64'(0));
    chk("mid_rst_ready", 64'(dr0), 64'(0));
    chk("mid_rst_valid", 64'(ov0), 64'(0));
    chk("mid_rst_grad", 64'(g0), 64'(0));
    chk("mid_rst_dop", 64'(dop0), 64'(0));
    chk("mid_rst_row", 64'(row0), 64'(0));
    chk("mid_rst_col", 64'(col0), 64'(0));
    chk("mid_rst_finish", 64'(fin0), 64'(0));
    @(posedge CLK); #1;
    Reset = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    chk("no_finish_after_reset", 64'(fin_cnt0), 64'(4));
    chk("no_output_after_reset", 64'(ov0), 64'(0));

    // full random frame after the reset
    fill_rand();
    thr = int'($urandom_range(0, 255));
    push_expected(thr);
    start_frame(thr);
    send_frame(N, 1, 0);
    wait_finish(5);
    #1;
    chk("queue0_drained", 64'(exp_q0.size()), 64'(0));
    chk("queue1_drained", 64'(exp_q1.size()), 64'(0));
    chk("finish_count1", 64'(fin_cnt1), 64'(5));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_stream.md
SOBEL_STREAM -- requirements
Module: sobel_stream

Interface
REQ-001 Parameter PIX_W, default 8, pixel and threshold width in bits.
REQ-002 Parameter IMG_W, default 256, pixels per row (>=3).
REQ-003 Parameter IMG_H, default 256, rows per frame (>=3).
REQ-004 Parameter MODE, default 0, magnitude rule: 0 = |Gx|+|Gy|, 1 = max(|Gx|,|Gy|).
REQ-005 CLK  input  1  sole clock, rising-edge active.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 Start  input  1  frame start request, sampled in IDLE only.
REQ-008 Threshold  input  PIX_W  edge threshold, captured on accepted Start.
REQ-009 DataIn  input  PIX_W  raster-order pixel.
REQ-010 DataValid  input  1  DataIn valid.
REQ-011 DataReady  output  1  block accepts DataIn this cycle.
REQ-012 OutReady  input  1  downstream accepts result.
REQ-013 OutValid  output  1  result outputs valid.
REQ-014 Gradient  output  PIX_W  saturated gradient magnitude.
REQ-015 Dop  output  1  edge flag: Gradient > captured Threshold.
REQ-016 OutRow / OutCol  output  16 each  coordinates of current result.
REQ-017 Finish  output  1  one-cycle pulse after the last result of a frame.
REQ-018 State  output  2  FSM state: 0 IDLE, 1 RUN, 2 FLUSH, 3 DONE.

Function
REQ-019 FSM: IDLE -> RUN on Start=1; RUN -> FLUSH after pixel IMG_W*IMG_H-1 accepted; FLUSH -> DONE after final result transferred; DONE -> IDLE next cycle.
REQ-020 Start ignored outside IDLE; DataReady=0 outside RUN.
REQ-021 Input transfer = DataValid & DataReady; DataReady = (State==RUN) & (~OutValid | OutReady).
REQ-022 Output transfer = OutValid & OutReady; OutValid, Gradient, Dop, OutRow, OutCol held stable while OutValid=1 and OutReady=0.
REQ-023 Two line buffers of IMG_W x PIX_W plus 3x3 window registers; window advances only on input transfer (RUN) or flush step (FLUSH).
REQ-024 Neighbours outside the image are zero (row -1, row IMG_H, col -1, col IMG_W); implemented by masking, no line-buffer clearing.
REQ-025 Gx = right column minus left column, weights 1,2,1; Gy = bottom row minus top row, weights 1,2,1; signed width PIX_W+4.
REQ-026 Magnitude per MODE computed at full width, then saturated to 2^PIX_W-1.
REQ-027 Result (r,c) becomes valid one cycle after the window centred on (r,c) is complete, i.e. after input pixel r*IMG_W+c+IMG_W+1 is accepted, or the equivalent flush step.
REQ-028 FLUSH injects IMG_W+1 zero positions, one per cycle when ~OutValid | OutReady, producing the remaining results.
REQ-029 Exactly IMG_W*IMG_H results per frame in raster order; OutCol wraps IMG_W-1 -> 0 with OutRow increment.
REQ-030 Finish=1 for exactly one cycle, in DONE state; all other times 0.
REQ-031 Back-to-back frames: Start asserted during DONE is ignored; accepted in the following IDLE cycle.

Reset
REQ-032 Reset=1 forces State=IDLE, DataReady=0, OutValid=0, Gradient=0, Dop=0, OutRow=0, OutCol=0, Finish=0, captured threshold=0, all counters 0.
REQ-033 Reset has priority over every other input, including mid-frame and during FLUSH; partial frame discarded, no Finish.

Verification
REQ-034 IMG_W=IMG_H=4, MODE=0, all pixels 10, Threshold=10 -> result (0,0)=60 Dop=1, (0,1)=40 Dop=1, (1,1)=0 Dop=0; 16 results, one Finish.
REQ-035 Same image, MODE=1 -> (0,0)=30, (0,1)=40, (1,1)=0.
REQ-036 PIX_W=8, all pixels 255 -> (0,0) raw 1530 saturates to Gradient=255, Dop=1 for Threshold=10.
REQ-037 Random OutReady and DataValid toggling -> outputs held while stalled, results bit-identical to unstalled run, no loss or duplication.
REQ-038 Reset asserted at pixel 7 of a 4x4 frame -> next cycle State=0, all outputs 0, no Finish; new Start gives correct full frame.
REQ-039 Start pulsed during RUN and DONE -> ignored; exactly one frame of results per accepted Start.
